// File: rtl/nios_pio_pkg.sv
// Shared constants for the gen2 Nios PIO: register word addresses and edge-type selectors.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_gen2_if.sv
// Avalon-MM slave bus bundle for the gen2 PIO: master drives address/strobes, slave returns readdata.
interface nios_pio_gen2_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/nios_pio_sync.sv
// Input synchroniser chain plus one-cycle delayed copy; edge_pulse flags edges of the selected type.
module nios_pio_sync
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] r_syncChain [SYNC_STAGES];
  logic [WIDTH-1:0] r_delayed;
  logic [WIDTH-1:0] w_edge;

  // Chain and delay both clear to 0, so the first cycle after reset sees no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_syncChain[i] <= '0;
      end
      r_delayed <= '0;
    end else begin
      r_syncChain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_syncChain[i] <= r_syncChain[i-1];
      end
      r_delayed <= r_syncChain[SYNC_STAGES-1];
    end
  end

  assign in_sync = r_syncChain[SYNC_STAGES-1];

  always_comb begin
    w_edge = in_sync ^ r_delayed;
    case (EDGE_TYPE)
      EDGE_RISE: w_edge = in_sync & ~r_delayed;
      EDGE_FALL: w_edge = ~in_sync & r_delayed;
      default:   w_edge = in_sync ^ r_delayed;
    endcase
  end

  assign edge_pulse = w_edge;

endmodule

// File: rtl/nios_pio_gen2.sv
// Gen2 Nios PIO slave: data/dir/irqmask/edgecap registers, registered read mux and level irq.
// Define NIOS_PIO_BITSET_EN to add write-only OUTSET (addr 4) and OUTCLEAR (addr 5).
module nios_pio_gen2
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  nios_pio_gen2_if.slave    bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  dir_port,
  output logic              irq
);

  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irqMask;
  logic [WIDTH-1:0] r_edgeCap;
  logic [31:0]      r_readData;
  logic             r_irq;

  logic             w_write;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_inSync;
  logic [WIDTH-1:0] w_edgePulse;
  logic [WIDTH-1:0] w_clear;
  logic [31:0]      w_readMux;
  logic             w_unusedWd;

  nios_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .in_sync    (w_inSync),
    .edge_pulse (w_edgePulse)
  );

  assign w_write    = bus.chipselect & ~bus.write_n;
  assign w_wd       = bus.writedata[WIDTH-1:0];
  assign w_unusedWd = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dataOut <= RESET_OUT;
      r_dir     <= '0;
      r_irqMask <= '0;
    end else if (w_write) begin
      case (bus.address)
        ADDR_DATA:     r_dataOut <= w_wd;
        ADDR_DIR:      r_dir     <= w_wd;
        ADDR_IRQMASK:  r_irqMask <= w_wd;
`ifdef NIOS_PIO_BITSET_EN
        ADDR_OUTSET:   r_dataOut <= r_dataOut | w_wd;
        ADDR_OUTCLEAR: r_dataOut <= r_dataOut & ~w_wd;
`endif
        default: ;
      endcase
    end
  end

  // Clear-then-set ordering makes a coincident new edge win over the W1C write.
  assign w_clear = (w_write && (bus.address == ADDR_EDGECAP)) ? w_wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgeCap <= '0;
    end else begin
      r_edgeCap <= (r_edgeCap & ~w_clear) | (w_edgePulse & ~r_dir);
    end
  end

  always_comb begin
    w_readMux = '0;
    case (bus.address)
      ADDR_DATA:    w_readMux = 32'((r_dir & r_dataOut) | (~r_dir & w_inSync));
      ADDR_DIR:     w_readMux = 32'(r_dir);
      ADDR_IRQMASK: w_readMux = 32'(r_irqMask);
      ADDR_EDGECAP: w_readMux = 32'(r_edgeCap);
      default:      w_readMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readData <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readData <= w_readMux;
      r_irq      <= |(r_edgeCap & r_irqMask);
    end
  end

  assign bus.readdata = r_readData;
  assign out_port     = r_dataOut;
  assign dir_port     = r_dir;
  assign irq          = r_irq;

endmodule

// File: tb/tb_nios_pio_gen2.sv
// Directed bench for nios_pio_gen2 (WIDTH=8, SYNC_STAGES=2, rising edge, RESET_OUT=A5).
module tb_nios_pio_gen2;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic [7:0] dir_port;
  logic       irq;
  int         vecCount;
  int         missCount;

  nios_pio_gen2_if bus ();

  nios_pio_gen2 #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .RESET_OUT   (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .dir_port (dir_port),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus cycle starting and ending on a negedge; a read leaves readdata valid on return.
  task automatic applyStimulus(input logic isWrite, input logic [2:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = ~isWrite;
    bus.writedata  = data;
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecCount       = 0;
    missCount      = 0;
    reset_n        = 1'b0;
    in_port        = 8'h00;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;

    waitCycles(2);
    checkOutput("rst_out_port", 32'(out_port), 32'h0000_00A5);
    checkOutput("rst_dir_port", 32'(dir_port), 32'h0000_0000);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;

    // Inputs rise while all bits are inputs: bits 7 and 5 capture.
    in_port = 8'hA0;
    waitCycles(4);
    applyStimulus(1'b0, 3'd3, 32'h0);
    checkOutput("edgecap_A0", bus.readdata, 32'h0000_00A0);
    checkOutput("irq_masked_off", 32'(irq), 32'h0);
    applyStimulus(1'b1, 3'd3, 32'h0000_00FF);
    applyStimulus(1'b0, 3'd3, 32'h0);
    checkOutput("edgecap_cleared", bus.readdata, 32'h0);

    applyStimulus(1'b1, 3'd1, 32'h0000_000F);
    applyStimulus(1'b1, 3'd0, 32'h0000_003C);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("data_mixed_AC", bus.readdata, 32'h0000_00AC);
    checkOutput("out_port_3C", 32'(out_port), 32'h0000_003C);
    checkOutput("dir_port_0F", 32'(dir_port), 32'h0000_000F);

    applyStimulus(1'b1, 3'd1, 32'h0000_0000);
    applyStimulus(1'b1, 3'd2, 32'h0000_0001);
    applyStimulus(1'b0, 3'd2, 32'h0);
    checkOutput("irqmask_rd", bus.readdata, 32'h0000_0001);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("data_all_in_A0", bus.readdata, 32'h0000_00A0);

    // Bit0 rises: captured at the 3rd posedge, irq follows at the 4th.
    in_port = 8'hA1;
    waitCycles(3);
    checkOutput("irq_not_yet", 32'(irq), 32'h0);
    waitCycles(1);
    checkOutput("irq_set", 32'(irq), 32'h1);
    applyStimulus(1'b0, 3'd3, 32'h0);
    checkOutput("edgecap_01", bus.readdata, 32'h0000_0001);

    // W1C lands on the same edge as a fresh capture: set wins.
    in_port = 8'hA0;
    waitCycles(4);
    checkOutput("irq_hold", 32'(irq), 32'h1);
    in_port = 8'hA1;
    waitCycles(2);
    applyStimulus(1'b1, 3'd3, 32'h0000_0001);
    applyStimulus(1'b0, 3'd3, 32'h0);
    checkOutput("edgecap_set_wins", bus.readdata, 32'h0000_0001);
    checkOutput("irq_set_wins", 32'(irq), 32'h1);

    // Plain W1C: edgecap clears now, irq drops one cycle later.
    applyStimulus(1'b1, 3'd3, 32'h0000_0001);
    checkOutput("irq_lag", 32'(irq), 32'h1);
    applyStimulus(1'b0, 3'd3, 32'h0);
    checkOutput("edgecap_w1c", bus.readdata, 32'h0);
    checkOutput("irq_cleared", 32'(irq), 32'h0);

    applyStimulus(1'b1, 3'd1, 32'h0000_00FF);
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FF5A);
    checkOutput("out_port_upper_ignored", 32'(out_port), 32'h0000_005A);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("data_rd_upper_zero", bus.readdata, 32'h0000_005A);
    applyStimulus(1'b0, 3'd7, 32'h0);
    checkOutput("unmapped_rd", bus.readdata, 32'h0);
    applyStimulus(1'b1, 3'd6, 32'h0000_0000);
    checkOutput("unmapped_wr", 32'(out_port), 32'h0000_005A);

`ifdef NIOS_PIO_BITSET_EN
    applyStimulus(1'b1, 3'd0, 32'h0000_00F0);
    applyStimulus(1'b1, 3'd4, 32'h0000_0003);
    checkOutput("outset_F3", 32'(out_port), 32'h0000_00F3);
    applyStimulus(1'b1, 3'd5, 32'h0000_0080);
    checkOutput("outclear_73", 32'(out_port), 32'h0000_0073);
    applyStimulus(1'b0, 3'd4, 32'h0);
    checkOutput("outset_rd0", bus.readdata, 32'h0);
`else
    applyStimulus(1'b1, 3'd4, 32'h0000_0003);
    checkOutput("addr4_wr_ignored", 32'(out_port), 32'h0000_005A);
    applyStimulus(1'b1, 3'd5, 32'h0000_00FF);
    checkOutput("addr5_wr_ignored", 32'(out_port), 32'h0000_005A);
    applyStimulus(1'b0, 3'd4, 32'h0);
    checkOutput("addr4_rd0", bus.readdata, 32'h0);
`endif

    // Reset asserted in the middle of a write cycle.
    bus.address    = 3'd0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 32'h0000_0011;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_port", 32'(out_port), 32'h0000_00A5);
    checkOutput("midrst_dir_port", 32'(dir_port), 32'h0);
    checkOutput("midrst_readdata", bus.readdata, 32'h0);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    reset_n        = 1'b1;
    waitCycles(1);
    checkOutput("postrst_out_port", 32'(out_port), 32'h0000_00A5);
    checkOutput("postrst_irq", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
